// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Constants and types shared by both ends of the UART link (uart_tx and
// uart_rx). Keeping the baud arithmetic and frame shape in one place means
// the two ends cannot drift apart.
//   BASE_FREQ       clk frequency in Hz
//   BAUDRATE        line bit rate
//   COUNTS_PER_BIT  clk cycles per line bit (integer division)
//   FRAME_BITS      start + 8 data + parity + stop
//   rx_state_t      receiver FSM state encoding
//   even_parity()   parity bit that makes the set-bit count even
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int BASE_FREQ      = 50_000_000;
    localparam int BAUDRATE       = 115_200;
    localparam int COUNTS_PER_BIT = BASE_FREQ / BAUDRATE;
    localparam int DATA_BITS      = 8;
    localparam int FRAME_BITS     = 11;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    // Parity bit the transmitter appends so data plus parity has an even
    // number of ones.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// ---------------------------------------------------------------------------
// uart_rx_if
// Signal bundle between the UART receiver and its environment.
//   serial_in   asynchronous RX line, idles high
//   data_out    last received byte
//   data_valid  one-clk pulse per completed frame
//   parity_err  parity mismatch on the last frame
//   frame_err   stop bit sampled low on the last frame
// Modports:
//   master  the receiver itself (consumes the line, drives the byte/status)
//   slave   the surrounding logic (drives the line, consumes the byte/status)
// ---------------------------------------------------------------------------
interface uart_rx_if;

    logic       serial_in;
    logic [7:0] data_out;
    logic       data_valid;
    logic       parity_err;
    logic       frame_err;

    modport master (
        input  serial_in,
        output data_out,
        output data_valid,
        output parity_err,
        output frame_err
    );

    modport slave (
        output serial_in,
        input  data_out,
        input  data_valid,
        input  parity_err,
        input  frame_err
    );

endinterface

// File: rtl/uart_sync.sv
// ---------------------------------------------------------------------------
// uart_sync
// N-flop synchronizer for an asynchronous single-bit input. Every flop
// resets to RST_VAL so an idle-high line does not look like a falling edge
// while reset is released.
//   clk  system clock
//   rst  asynchronous active-low reset
//   d    asynchronous input
//   q    synchronized output (N clk of latency)
// ---------------------------------------------------------------------------
module uart_sync #(
    parameter int   N       = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [N-1:0] sync_ff;

    // NOTE: flops are written with <= so every stage samples the value the
    // previous stage held before this edge; = would collapse the chain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_ff <= {N{RST_VAL}};
        end else begin
            sync_ff <= {sync_ff[N-2:0], d};
        end
    end

    assign q = sync_ff[N-1];

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// UART receiver: 1 start, 8 data (LSB first), 1 even-parity, 1 stop bit.
// The line is synchronized, a falling edge starts a frame, the start bit is
// re-checked at its centre and every following bit is sampled one bit period
// later, i.e. at its centre. Each completed frame (including bad ones)
// updates data_out and both flags and pulses data_valid for one clk.
//   clk             system clock
//   rst             asynchronous active-low reset
//   bus.serial_in   RX line (asynchronous, idles high)
//   bus.data_out    last received byte, held until the next frame completes
//   bus.data_valid  one-clk pulse per completed frame
//   bus.parity_err  parity mismatch on the last frame
//   bus.frame_err   stop bit sampled low on the last frame
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int BASE_FREQ      = uart_pkg::BASE_FREQ,
    parameter int BAUDRATE       = uart_pkg::BAUDRATE,
    parameter int COUNTS_PER_BIT = BASE_FREQ / BAUDRATE,
    parameter int HALF_BIT       = COUNTS_PER_BIT / 2
) (
    input  logic     clk,
    input  logic     rst,
    uart_rx_if.master bus
);

    import uart_pkg::rx_state_t;
    import uart_pkg::RX_IDLE;
    import uart_pkg::RX_START;
    import uart_pkg::RX_DATA;
    import uart_pkg::RX_PARITY;
    import uart_pkg::RX_STOP;
    import uart_pkg::even_parity;

    // One extra count is needed in RX_STOP to register the frame the cycle
    // after the stop bit is sampled.
    localparam int CNT_W = $clog2(COUNTS_PER_BIT + 1);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(COUNTS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_END   = CNT_W'(COUNTS_PER_BIT);

    logic rx_s;
    logic rx_d;

    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic             stop_q, stop_d;
    logic [7:0]       data_q, data_d;
    logic             dv_q, dv_d;
    logic             pe_q, pe_d;
    logic             fe_q, fe_d;

    uart_sync #(.N(2), .RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.serial_in),
        .q   (rx_s)
    );

    // Edge-detect register; resets high to match the idle line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_d <= 1'b1;
        end else begin
            rx_d <= rx_s;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            stop_q  <= 1'b1;
            data_q  <= '0;
            dv_q    <= 1'b0;
            pe_q    <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            stop_q  <= stop_d;
            data_q  <= data_d;
            dv_q    <= dv_d;
            pe_q    <= pe_d;
            fe_q    <= fe_d;
        end
    end

    always_comb begin
        // NOTE: every signal gets a hold/default value first so no path
        // through the case below leaves one unassigned (which would infer a
        // latch).
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        stop_d  = stop_q;
        data_d  = data_q;
        pe_d    = pe_q;
        fe_d    = fe_q;
        dv_d    = 1'b0;

        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                // Edge, not level: a line stuck low cannot retrigger.
                if (rx_d && !rx_s) begin
                    state_d = RX_START;
                end
            end

            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    // High at the start-bit centre means a glitch.
                    state_d = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            RX_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = RX_PARITY;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            RX_PARITY: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    par_d   = rx_s;
                    state_d = RX_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            RX_STOP: begin
                if (cnt_q == BIT_END) begin
                    // Leaving at mid-stop-bit keeps back-to-back frames.
                    data_d  = shift_q;
                    pe_d    = even_parity(shift_q) ^ par_q;
                    fe_d    = ~stop_q;
                    dv_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                end else begin
                    if (cnt_q == BIT_LAST) begin
                        stop_d = rx_s;
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = RX_IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    assign bus.data_out   = data_q;
    assign bus.data_valid = dv_q;
    assign bus.parity_err = pe_q;
    assign bus.frame_err  = fe_q;

endmodule
